// File: rtl/alu_mc.sv
`timescale 1ns/1ps
// alu_mc: multi-cycle execute-stage ALU with a valid/ready handshake.
//
// Purpose:
//   Accepts one operation at a time. Logic, add/sub, compare and shift ops
//   register their result in the cycle after accept. MUL/MULHU run an
//   iterative shift-add over WIDTH cycles. The result is held until the
//   consumer takes it. A synchronous flush squashes any in-flight or held op.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (also clears result/accumulator)
//   flush      synchronous abort; a request presented with flush is dropped
//   in_valid   request present
//   in_ready   block is idle and can take a request
//   operation  4-bit opcode, sampled on accept
//   operand_a  first operand, sampled on accept
//   operand_b  second operand, sampled on accept
//   out_valid  result available
//   out_ready  consumer takes the result
//   result     registered result
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_SLL   = 4'b1010;
    localparam logic [3:0] OP_SRL   = 4'b1011;
    localparam logic [3:0] OP_SRA   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1101;
    localparam logic [3:0] OP_MULHU = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SHAMT_W-1:0]   cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 mul_hi;

    logic                 accept;
    logic                 is_mul;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   acc_add;

    // Single-cycle operations; ZERO (0000/0011) and reserved (1111) fall to 0.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHAMT_W-1:0]      sh;
        sa = a;
        sb = b;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_OR:   return a | b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return sa >>> sh;
            default: return '0;
        endcase
    endfunction

    // Flush blocks acceptance so a request presented alongside it is dropped.
    assign accept    = in_valid && in_ready && !flush;
    assign is_mul    = (operation == OP_MUL) || (operation == OP_MULHU);
    assign last_iter = (cnt == SHAMT_W'(WIDTH - 1));
    // One multiplier bit per cycle, LSB first; mcand already holds a << i.
    assign acc_add   = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nxt = is_mul ? BUSY : DONE;
            end
            BUSY: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    // accept boundary: latch operands, seed the multiplier
                    IDLE: begin
                        if (accept) begin
                            cnt    <= '0;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, operand_a};
                            mplier <= operand_b;
                            mul_hi <= operation[1];
                            if (!is_mul)
                                result <= alu_single(operation, operand_a, operand_b);
                        end
                    end
                    // iteration boundary: one shift-add step per cycle
                    BUSY: begin
                        acc    <= acc_add;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (last_iter)
                            result <= mul_hi ? acc_add[2*WIDTH-1:WIDTH]
                                             : acc_add[WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  operation;
    logic [31:0] operand_a, operand_b, result;

    int n_cmp = 0;
    int n_fail = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[20];

    // Reference model straight from the opcode table, using full-width arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        int          sh;
        prod = 64'(a) * 64'(b);
        sh   = int'(b % 32);
        case (op)
            4'd1:  return a + b;
            4'd2:  return a | b;
            4'd4:  return a - b;
            4'd5:  return a & b;
            4'd6:  return a ^ b;
            4'd7:  return ~(a | b);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return a << sh;
            4'd11: return a >> sh;
            4'd12: return 32'($signed(a) >>> sh);
            4'd13: return prod[31:0];
            4'd14: return prod[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle. Returns result, cycles to out_valid,
    // and whether in_ready was seen high while waiting.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat, output logic ir_busy);
        operation = op; operand_a = a; operand_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        operand_a = $urandom; operand_b = $urandom; operation = 4'($urandom);
        lat = 1; ir_busy = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ir_busy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        r = result;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic watch_no_valid(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        logic        irb;
        logic [3:0]  op;
        logic [31:0] a, b;

        tbl[0]  = '{4'b0001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1};
        tbl[1]  = '{4'b0010, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1};
        tbl[2]  = '{4'b0000, 32'h12345678, 32'h00000009, 32'h00000000, 1};
        tbl[3]  = '{4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1};
        tbl[4]  = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
        tbl[5]  = '{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
        tbl[6]  = '{4'b1100, 32'h80000000, 32'h00000104, 32'hF8000000, 1};
        tbl[7]  = '{4'b1010, 32'h00000001, 32'd31,       32'h80000000, 1};
        tbl[8]  = '{4'b1101, 32'h00010000, 32'h00010000, 32'h00000000, 33};
        tbl[9]  = '{4'b1110, 32'h00010000, 32'h00010000, 32'h00000001, 33};
        tbl[10] = '{4'b0100, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1};
        tbl[11] = '{4'b0101, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1};
        tbl[12] = '{4'b0110, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1};
        tbl[13] = '{4'b0111, 32'hF0F00000, 32'h0000F0F0, 32'h0F0F0F0F, 1};
        tbl[14] = '{4'b1011, 32'h80000000, 32'h00000024, 32'h08000000, 1};
        tbl[15] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1};
        tbl[16] = '{4'b1101, 32'h12345678, 32'h00000010, 32'h23456780, 33};
        tbl[17] = '{4'b1110, 32'h12345678, 32'h00000010, 32'h00000001, 33};
        tbl[18] = '{4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        tbl[19] = '{4'b1000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operation = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        foreach (tbl[i]) begin
            check($sformatf("tbl%0d in_ready idle", i), 32'(in_ready), 32'd1);
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, lat, irb);
            check($sformatf("tbl%0d op%0h result", i, tbl[i].op), r, tbl[i].exp);
            check($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].lat));
            if (tbl[i].lat > 1) check($sformatf("tbl%0d in_ready while busy", i), 32'(irb), 32'd0);
            release_result();
        end

        // Backpressure: result holds, in_ready low, other requests ignored
        do_op(4'b0001, 32'd10, 32'd20, r, lat, irb);
        check("bp result", r, 32'd30);
        operation = 4'b0100; operand_a = 32'hDEAD; operand_b = 32'hBEEF; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp hold%0d result", k), result, 32'd30);
            check($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_result();
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release out_valid", 32'(out_valid), 32'd0);

        // Flush at iteration 10 of a multiply
        operation = 4'b1101; operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mul busy in_ready", 32'(in_ready), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        watch_no_valid("flush no late out_valid", 40);
        do_op(4'b0001, 32'd3, 32'd4, r, lat, irb);
        check("post-flush add result", r, 32'd7);
        check("post-flush add latency", 32'(lat), 32'd1);
        release_result();

        // Flush while DONE with a request presented: dropped and not accepted
        do_op(4'b0110, 32'h0F0F0F0F, 32'hFFFFFFFF, r, lat, irb);
        check("xor result", r, 32'hF0F0F0F0);
        flush = 1'b1; in_valid = 1'b1; operation = 4'b0001; operand_a = 32'd1; operand_b = 32'd1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush done out_valid", 32'(out_valid), 32'd0);
        check("flush done in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("flush request not accepted", 32'(out_valid), 32'd0);

        // Reset while DONE
        do_op(4'b0001, 32'd3, 32'd4, r, lat, irb);
        check("pre-reset result", r, 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst done out_valid", 32'(out_valid), 32'd0);
        check("rst done result", result, 32'd0);
        check("rst done in_ready", 32'(in_ready), 32'd1);

        // Reset while BUSY discards the multiply
        operation = 4'b1110; operand_a = 32'h00010000; operand_b = 32'h00010000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst busy in_ready", 32'(in_ready), 32'd1);
        watch_no_valid("rst busy no out_valid", 40);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = a & 32'h0000FFFF;
            do_op(op, a, b, r, lat, irb);
            check($sformatf("rnd%0d op%0h a=%08h b=%08h", n, op, a, b), r, ref_alu(op, a, b));
            check($sformatf("rnd%0d latency", n), 32'(lat),
                  (op == 4'd13 || op == 4'd14) ? 32'd33 : 32'd1);
            release_result();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the 2-bit-opcode combinational ALU in the execute stage.
- Accepts one operation at a time over a valid/ready handshake.
- Single-cycle ops (logic, add/sub, compare, shifts) register their result after one cycle. Multiply (low and high words) runs as an iterative shift-add over WIDTH cycles.
- Holds the result until the consumer accepts it; supports a synchronous flush for pipeline squash.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, 8..64.
- SHAMT_W, $clog2(WIDTH), local: shift-amount width (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- operation  in  4  opcode, sampled on accept.
- operand_a  in  WIDTH  first operand, sampled on accept.
- operand_b  in  WIDTH  second operand, sampled on accept.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.

Behaviour:
- Opcodes:
  - 0000 ZERO
  - 0001 ADD a+b (mod 2^WIDTH)
  - 0010 OR
  - 0011 ZERO
  - 0100 SUB a-b
  - 0101 AND
  - 0110 XOR
  - 0111 NOR
  - 1000 SLT signed (result 1/0, zero-extended)
  - 1001 SLTU unsigned
  - 1010 SLL a<<b[SHAMT_W-1:0]
  - 1011 SRL logical
  - 1100 SRA arithmetic
  - 1101 MUL low WIDTH bits of unsigned a*b
  - 1110 MULHU high WIDTH bits of unsigned a*b
  - 1111 reserved, result 0
- Encodings 0000–0011 match the legacy 2-bit ALU exactly (zero-extended opcode).
- Shifts use only b[SHAMT_W-1:0]; upper bits of b are ignored.
- Accept = in_valid & in_ready at a rising edge.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - Accept of a single-cycle op → DONE, result computed from the sampled operands.
    - Accept of MUL/MULHU → BUSY, iteration counter=0, 2*WIDTH-bit product accumulator=0.
  - BUSY: in_ready=0, out_valid=0.
    - Each cycle processes one multiplier bit, LSB first: if the bit is set, add multiplicand<<i into the accumulator.
    - After the WIDTH-th iteration → DONE, result = low or high half per the latched opcode.
  - DONE: out_valid=1, in_ready=0; result stable.
    - out_ready=1 → IDLE.
    - No back-to-back accept in the same cycle as a DONE→IDLE transition.
- Latency (accept at edge N):
  - single-cycle ops: out_valid high after edge N+1.
  - MUL/MULHU: out_valid high after edge N+WIDTH+1.
- Throughput: single-cycle op with out_ready held high = one result every 2 cycles.
- Inputs are ignored unless accepted; operand changes after accept do not affect the in-flight op.
- flush=1: next state IDLE, out_valid=0, counter cleared. Flush overrides out_ready and in_valid in the same cycle; a request presented during flush is not accepted.
- rst=1: same as flush, plus result=0 and accumulator=0.
  - Reset values: in_ready=1, out_valid=0, result=0.
  - Reset asserted in BUSY or DONE discards the operation; no out_valid pulse follows.
- Reserved opcode completes as a single-cycle op with result 0.
- No overflow or flag outputs; wrap-around is silent.

Test Plan:
- Legacy ops, WIDTH=32: ADD 0xFFFFFFFF+0x00000002 → result 0x00000001 one cycle after accept; OR 0xF0F00000|0x0000F0F0 → 0xF0F0F0F0; opcodes 0000 and 0011 → 0.
- Compare and shift: SLT a=0xFFFFFFFF, b=1 → 1; SLTU with the same operands → 0; SRA 0x80000000 by b=0x00000104 (amount 4) → 0xF8000000; SLL 1 by 31 → 0x80000000.
- Multiply: MUL 0x0001_0000*0x0001_0000 → 0x00000000; MULHU on the same operands → 0x00000001. out_valid rises exactly 33 cycles after accept; in_ready stays 0 throughout.
- Backpressure: out_ready=0 for 5 cycles after a result → result and out_valid hold, in_ready=0. Raising out_ready → in_ready=1 on the next cycle.
- Flush mid-MUL at iteration 10 → in_ready=1 next cycle, no out_valid. A following ADD 3+4 returns 7 with normal latency.
- Reset in DONE state → out_valid=0, result=0, in_ready=1 on the next cycle.
